// File: rtl/prefetch_ctrl_if.sv
// prefetch_ctrl_if: bus handshake and FIFO-side signals of prefetch_ctrl.
// err_i/err_o exist only when PREFETCH_ERR_EN is defined.
interface prefetch_ctrl_if;
   logic        req_o;
   logic [31:0] addr_o;
   logic        gnt_i;
   logic        rvalid_i;
   logic [31:0] rdata_i;
   logic        fifo_push_o;
   logic [31:0] fifo_data_o;
   logic        fifo_pop_i;
   logic        fifo_flush_o;
`ifdef PREFETCH_ERR_EN
   logic        err_i;
   logic        err_o;
`endif
   modport master (
      output req_o, addr_o, fifo_push_o, fifo_data_o, fifo_flush_o,
      input  gnt_i, rvalid_i, rdata_i, fifo_pop_i
`ifdef PREFETCH_ERR_EN
      , input err_i, output err_o
`endif
   );
   modport slave (
      input  req_o, addr_o, fifo_push_o, fifo_data_o, fifo_flush_o,
      output gnt_i, rvalid_i, rdata_i, fifo_pop_i
`ifdef PREFETCH_ERR_EN
      , output err_i, input err_o
`endif
   );
endinterface

// File: rtl/prefetch_ctrl.sv
// prefetch_ctrl: sequential instruction prefetcher feeding a sync_fifo with bounded outstanding requests.
// Define PREFETCH_ERR_EN to add errored-response handling (err_i/err_o on the interface).
module prefetch_ctrl #(
   parameter int DEPTH           = 8,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            enable_i,
   input  logic            flush_i,
   input  logic [31:0]     branch_addr_i,
   prefetch_ctrl_if.master bus
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FETCH = 1'b1;
   localparam int OW = $clog2(DEPTH) + 1;
   logic [0:0]    state_q, state_d;
   logic [31:0]   addr_q, addr_d, redir_q, redir_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [2:0]    outst_q, outst_d, discard_q, discard_d;
   logic          hold_q, hold_d, redir_v_q, redir_v_d, err_q, err_d;
   logic          issue, grant, rv, drop, bad, push, pop;
`ifdef PREFETCH_ERR_EN
   assign bad        = bus.err_i;
   assign bus.err_o  = err_q;
`else
   assign bad        = 1'b0;
`endif
   // A response with nothing outstanding is a protocol error and is ignored entirely.
   assign rv     = bus.rvalid_i & (outst_q != '0);
   assign drop   = (discard_q != '0) | flush_i;
   assign push   = rv & ~drop & ~bad;
   assign pop    = bus.fifo_pop_i & (occ_q != '0);
   assign issue  = (state_q == FETCH) & enable_i & ~err_q &
                   (int'(occ_q) + int'(outst_q) < DEPTH) & (int'(outst_q) < MAX_OUTSTANDING);
   assign bus.req_o        = hold_q | issue;
   assign grant            = bus.req_o & bus.gnt_i;
   assign bus.addr_o       = addr_q;
   assign bus.fifo_push_o  = push;
   assign bus.fifo_data_o  = bus.rdata_i;
   assign bus.fifo_flush_o = flush_i;
   always_comb begin
      state_d   = (state_q == IDLE) ? (enable_i ? FETCH : IDLE) : ((~enable_i & ~bus.req_o) ? IDLE : FETCH);
      hold_d    = bus.req_o & ~bus.gnt_i;
      occ_d     = flush_i ? '0 : occ_q + OW'(push) - OW'(pop);
      outst_d   = outst_q + 3'(grant) - 3'(rv);
      // A request still waiting for its grant at flush time is owed a discard once granted.
      discard_d = flush_i ? outst_d : discard_q - 3'(rv & (discard_q != '0)) + 3'(grant & redir_v_q);
      err_d     = ~flush_i & (err_q | (rv & ~drop & bad));
      redir_d   = flush_i ? {branch_addr_i[31:2], 2'b00} : redir_q;
      redir_v_d = flush_i ? hold_d : (redir_v_q & ~grant);
      addr_d    = (flush_i & ~hold_d) ? {branch_addr_i[31:2], 2'b00} :
                  grant ? (redir_v_q ? redir_q : addr_q + 32'd4) : addr_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         redir_q   <= '0;
         occ_q     <= '0;
         outst_q   <= '0;
         discard_q <= '0;
         hold_q    <= 1'b0;
         redir_v_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         redir_q   <= redir_d;
         occ_q     <= occ_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
         hold_q    <= hold_d;
         redir_v_q <= redir_v_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: doc/prefetch_ctrl.md
PREFETCH_CTRL -- requirements
Module: prefetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning capacity of the downstream sync_fifo, 1..256.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum granted-but-unanswered bus requests, 1..4.
REQ-003 SHALL have ports clk_i  in  1  clock (rising edge); rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports enable_i  in  1  fetch enable; flush_i  in  1  redirect strobe; branch_addr_i  in  32  redirect target.
REQ-005 SHALL have bus ports req_o  out  1; addr_o  out  32  word-aligned; gnt_i  in  1; rvalid_i  in  1; rdata_i  in  32.
REQ-006 SHALL have FIFO ports fifo_push_o  out  1; fifo_data_o  out  32; fifo_pop_i  in  1  accepted pop of the FIFO; fifo_flush_o  out  1.

Function
REQ-007 SHALL implement FSM IDLE/FETCH; IDLE->FETCH when enable_i=1; FETCH->IDLE when enable_i=0 and req_o=0.
REQ-008 SHALL assert req_o in FETCH only when occ + outst < DEPTH and outst < MAX_OUTSTANDING (occ = FIFO occupancy, outst = granted unanswered requests).
REQ-009 SHALL keep req_o and addr_o stable from assertion until the gnt_i=1 cycle, including when enable_i falls.
REQ-010 SHALL increment addr_o by 4 on each grant (req_o&gnt_i), 32-bit wrap 0xFFFFFFFC->0x00000000.
REQ-011 SHALL push rdata_i combinationally (fifo_push_o=rvalid_i, fifo_data_o=rdata_i, zero latency) unless the response is being discarded.
REQ-012 SHALL track occ internally: +1 on push, -1 on fifo_pop_i, unchanged on both; width $clog2(DEPTH)+1.
REQ-013 SHALL update outst: +1 on grant, -1 on rvalid_i, unchanged on both in the same cycle.
REQ-014 SHALL drive fifo_flush_o=flush_i combinationally and clear occ to 0 on flush_i.
REQ-015 On flush_i, SHALL load discard counter with outst minus any rvalid_i that cycle, plus 1 if a request is granted that cycle.
REQ-016 SHALL drop responses while discard>0, decrementing per rvalid_i; no push.
REQ-017 flush_i with req_o=1, gnt_i=0: SHALL hold the old request until granted, count it into discard, then issue branch_addr_i&~3.
REQ-018 flush_i otherwise: next addr_o SHALL be branch_addr_i with bits[1:0] forced to 0.
REQ-019 SHALL ignore rvalid_i when outst=0 (protocol error, no push, no underflow).
REQ-020 SHALL treat fifo_pop_i with occ=0 as no-op.

Reset
REQ-021 rst_ni=0 SHALL asynchronously force state IDLE, addr=0x00000000, occ=0, outst=0, discard=0.
REQ-022 During reset, req_o=0 and fifo_push_o=0; fifo_flush_o follows flush_i.
REQ-023 Reset mid-transaction SHALL abandon all outstanding requests without tracking.

Configuration
REQ-024 Macro PREFETCH_ERR_EN SHALL add ports err_i  in  1  (qualifies rvalid_i) and err_o  out  1.
REQ-025 With PREFETCH_ERR_EN: non-discarded errored response SHALL not push, SHALL set sticky err_o, and SHALL block new requests until flush_i or reset.
REQ-026 Without PREFETCH_ERR_EN: no err_i/err_o ports; all responses treated as good.

Verification
REQ-027 Reset, enable_i=1, gnt_i=1 always, one-cycle rvalid -> addr_o 0x0,0x4,0x8; pushes data in order.
REQ-028 DEPTH=4, no pops -> exactly 4 grants, req_o stays 0; one pop -> one new request.
REQ-029 Two outstanding, flush_i with branch_addr_i=0x1003 -> two responses dropped; next addr_o=0x1000; fifo_flush_o high one cycle.
REQ-030 req_o=1, gnt_i=0 at flush -> addr_o held until grant; its response dropped; then 0x2000 issued for branch_addr_i=0x2000.
REQ-031 addr 0xFFFFFFFC granted -> next addr_o=0x00000000.
REQ-032 PREFETCH_ERR_EN, err_i=1 on rvalid -> no push, err_o=1, req_o=0 until flush_i; flush clears err_o.
